// File: rtl/counter_sequencer_pkg.sv
// Shared types and constants for the LED counter sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  localparam logic [1:0] SPD_X1 = 2'd0;
  localparam logic [1:0] SPD_X2 = 2'd1;
  localparam logic [1:0] SPD_X4 = 2'd2;
  localparam logic [1:0] SPD_X8 = 2'd3;

  localparam int unsigned COUNT_W = 4;

endpackage

// File: rtl/counter_sequencer_tick_prescaler.sv
// Step prescaler: counts enabled cycles and flags a due step once value reaches limit-1.
module tick_prescaler #(
  parameter int unsigned PRESC_W = 28
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               clr_i,
  input  logic [PRESC_W-1:0] limit_i,
  output logic               due_o,
  output logic [PRESC_W-1:0] value_o
);

  logic [PRESC_W-1:0] value_q, value_d;

  // >= rather than == so a limit that shrinks below the current value steps at once
  always_comb begin
    due_o = en_i && (value_q >= (limit_i - PRESC_W'(1)));
  end

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (due_o) begin
      value_d = '0;
    end else if (en_i) begin
      value_d = value_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/clear sequencer for the 4-bit LED counter with an in_clk tick enable.
// Optional rate select on `speed` when COUNTER_SEQ_SPEED_SEL_EN is defined.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned DIVISOR = 125000000,
  parameter int unsigned PRESC_W = 28
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               dir,
`ifdef COUNTER_SEQ_SPEED_SEL_EN
  input  logic [1:0]         speed,
`endif
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               wrap,
  output logic               running
);

  localparam logic [PRESC_W-1:0] DIV_L = PRESC_W'(DIVISOR);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               tick_q, tick_d;
  logic               wrap_q, wrap_d;
  logic               running_q, running_d;
  logic [PRESC_W-1:0] limit;
  logic [PRESC_W-1:0] presc_val;
  logic               presc_en;
  logic               due;

`ifdef COUNTER_SEQ_SPEED_SEL_EN
  logic [PRESC_W-1:0] limit_shifted;
  // A shift that underflows to zero is treated as one step per cycle
  assign limit_shifted = DIV_L >> speed;
  assign limit = (limit_shifted == '0) ? PRESC_W'(1) : limit_shifted;
`else
  assign limit = DIV_L;
`endif

  // Stop or clear in the same cycle freeze the prescaler, so a due step is dropped
  assign presc_en = (state_q == RUN) && !stop && !clear;

  tick_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk_i   (in_clk),
    .rst_i   (rst),
    .en_i    (presc_en),
    .clr_i   (clear),
    .limit_i (limit),
    .due_o   (due),
    .value_o (presc_val)
  );

  always_ff @(posedge in_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !stop) state_d = RUN;
        RUN:     if (stop)           state_d = PAUSE;
        PAUSE:   if (start && !stop) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d   = count_q;
    tick_d    = 1'b0;
    wrap_d    = 1'b0;
    running_d = (state_d == RUN);
    if (clear) begin
      count_d = '0;
    end else if (due) begin
      tick_d = 1'b1;
      if (!dir) begin
        count_d = count_q + COUNT_W'(1);
        wrap_d  = (count_q == '1);
      end else begin
        count_d = count_q - COUNT_W'(1);
        wrap_d  = (count_q == '0);
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      count_q   <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign count   = count_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

  // IDLE is only entered through reset or clear, both of which zero the prescaler
  a_idle_presc_zero : assert property (@(posedge in_clk) disable iff (rst)
    (state_q != IDLE) || (presc_val == '0));

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with DIVISOR=4 and hand-computed expectations.
module tb_counter_sequencer;

  logic       in_clk = 1'b0;
  logic       rst    = 1'b1;
  logic       start  = 1'b0;
  logic       stop   = 1'b0;
  logic       clear  = 1'b0;
  logic       dir    = 1'b0;
  logic [1:0] speed  = 2'd0;
  logic [3:0] count;
  logic       tick;
  logic       wrap;
  logic       running;

  int n_checks = 0;
  int n_errors = 0;

  counter_sequencer #(
    .DIVISOR (4),
    .PRESC_W (28)
  ) dut (
    .in_clk  (in_clk),
    .rst     (rst),
    .start   (start),
    .stop    (stop),
    .clear   (clear),
    .dir     (dir),
`ifdef COUNTER_SEQ_SPEED_SEL_EN
    .speed   (speed),
`endif
    .count   (count),
    .tick    (tick),
    .wrap    (wrap),
    .running (running)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one cycle; outputs of the new cycle are stable afterwards
  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic wait_tick();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      if (tick) begin
        seen = 1'b1;
        break;
      end
    end
    check("tick_seen", 32'(seen), 1);
  endtask

  initial begin
    int tick_cnt;

    // Reset state
    step(); step();
    rst = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_wrap", 32'(wrap), 0);
    check("rst_running", 32'(running), 0);

    // Start latency: start in cycle c, ticks in c+5, c+9, c+13
    start = 1'b1; step(); start = 1'b0;
    check("start_running", 32'(running), 1);
    check("start_tick", 32'(tick), 0);
    for (int k = 2; k <= 13; k++) begin
      step();
      check("lat_tick", 32'(tick), (k == 5 || k == 9 || k == 13) ? 1 : 0);
      check("lat_count", 32'(count), (k >= 13) ? 3 : (k >= 9) ? 2 : (k >= 5) ? 1 : 0);
    end

    // Up wrap 15 -> 0
    for (int k = 0; k < 12; k++) wait_tick();
    check("up_count15", 32'(count), 15);
    check("up_nowrap", 32'(wrap), 0);
    wait_tick();
    check("up_wrap_count", 32'(count), 0);
    check("up_wrap", 32'(wrap), 1);
    step();
    check("up_wrap_pulse", 32'(wrap), 0);

    // Down wrap 0 -> 15
    dir = 1'b1;
    wait_tick();
    check("dn_wrap_count", 32'(count), 15);
    check("dn_wrap", 32'(wrap), 1);
    step();
    check("dn_wrap_pulse", 32'(wrap), 0);
    dir = 1'b0;

    // Pause two cycles after a tick, hold, then resume
    wait_tick();
    check("pre_pause_count", 32'(count), 0);
    step(); step();
    stop = 1'b1; step(); stop = 1'b0;
    check("pause_running", 32'(running), 0);
    tick_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (tick) tick_cnt++;
    end
    check("pause_no_ticks", 32'(tick_cnt), 0);
    check("pause_count_held", 32'(count), 0);
    start = 1'b1; step(); start = 1'b0;
    check("resume_running", 32'(running), 1);
    check("resume_tick0", 32'(tick), 0);
    step();
    check("resume_tick1", 32'(tick), 0);
    step();
    check("resume_tick2", 32'(tick), 1);
    check("resume_count", 32'(count), 1);

    // start and stop together in RUN: stop wins
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    check("ss_running", 32'(running), 0);
    tick_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (tick) tick_cnt++;
    end
    check("ss_no_ticks", 32'(tick_cnt), 0);
    check("ss_count", 32'(count), 1);

    // Clear in the cycle a step is due: prescaler held at 0 -> due three cycles into RUN
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("clr_pre_tick", 32'(tick), 0);
    clear = 1'b1; step(); clear = 1'b0;
    check("clr_count", 32'(count), 0);
    check("clr_tick", 32'(tick), 0);
    check("clr_running", 32'(running), 0);

    // Reset mid-RUN at count 7, then full start latency again
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < 7; k++) wait_tick();
    check("pre_rst_count", 32'(count), 7);
    step();
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_running", 32'(running), 0);
    check("mid_rst_tick", 32'(tick), 0);
    start = 1'b1; step(); start = 1'b0;
    check("rst_restart_running", 32'(running), 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      check("rst_restart_tick", 32'(tick), (k == 5) ? 1 : 0);
    end
    check("rst_restart_count", 32'(count), 1);

`ifdef COUNTER_SEQ_SPEED_SEL_EN
    // speed=2 -> limit 1: tick every RUN cycle after the first
    clear = 1'b1; step(); clear = 1'b0;
    speed = 2'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("spd2_tick", 32'(tick), 1);
      check("spd2_count", 32'(count), k);
    end

    // Switch speed 0 -> 3 with prescaler at 1: tick next cycle, then every cycle
    clear = 1'b1; step(); clear = 1'b0;
    speed = 2'd0;
    start = 1'b1; step(); start = 1'b0;
    step();
    check("spd_sw_pre", 32'(tick), 0);
    speed = 2'd3;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("spd_sw_tick", 32'(tick), 1);
      check("spd_sw_count", 32'(count), k);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
